// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: exception codes and merge helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pipe_pkg;

  localparam int EXC_W = 5;

  // MIPS cause codes carried down the pipe; zero means "no exception".
  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  // The oldest exception wins: anything raised upstream masks a code found here.
  function automatic logic [EXC_W-1:0] exc_merge(input logic [EXC_W-1:0] prior,
                                                 input logic [EXC_W-1:0] local_code);
    return (prior != EXC_NONE) ? prior : local_code;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones.
// Latency: count reflects an inc one clock after it is sampled.
// Backpressure: none; inc is sampled every cycle.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Increment only when asked and not already full, so the count never wraps.
  always_comb begin
    count_d = count_q;
    if (inc && !(&count_q)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with kill, bubble flush, stall hold and exception merge.
// Latency: 1 cycle input to output.
// Backpressure: stall holds all contents and counts held cycles; kill and flush override stall.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W        = 128,
  parameter int EXC_W         = pipe_pkg::EXC_W,
  parameter int CNT_W         = 16,
  parameter bit FLUSH_KEEP_PC = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              int_req,
  input  logic              eret,
  input  logic              flush,
  input  logic              stall,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] payload_in,
  input  logic [31:0]       pc_in,
  input  logic              bd_in,
  input  logic [EXC_W-1:0]  exc_in,
  input  logic [EXC_W-1:0]  local_exc,
  output logic              valid_out,
  output logic [DATA_W-1:0] payload_out,
  output logic [31:0]       pc_out,
  output logic              bd_out,
  output logic [EXC_W-1:0]  exc_out,
  output logic              has_exc,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              valid_q,   valid_d;
  logic [DATA_W-1:0] payload_q, payload_d;
  logic [31:0]       pc_q,      pc_d;
  logic              bd_q,      bd_d;
  logic [EXC_W-1:0]  exc_q,     exc_d;
  logic [EXC_W-1:0]  eff_exc;
  logic              stall_inc;

  assign eff_exc = exc_merge(exc_in, local_exc);

  // Priority select: kill > flush > stall > bubble pass > exception load > normal load.
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    pc_d      = pc_q;
    bd_d      = bd_q;
    exc_d     = exc_q;
    stall_inc = 1'b0;
    if (int_req || eret) begin
      valid_d   = 1'b0;
      payload_d = '0;
      pc_d      = '0;
      bd_d      = 1'b0;
      exc_d     = '0;
    end else if (flush) begin
      // The bubble may keep the PC so a later EPC capture still points at the right slot.
      valid_d   = 1'b0;
      payload_d = '0;
      exc_d     = '0;
      pc_d      = FLUSH_KEEP_PC ? pc_in : 32'd0;
      bd_d      = FLUSH_KEEP_PC ? bd_in : 1'b0;
    end else if (stall) begin
      stall_inc = 1'b1;
    end else if (!valid_in) begin
      // A non-instruction slot can never raise an exception.
      valid_d   = 1'b0;
      payload_d = '0;
      exc_d     = '0;
      pc_d      = pc_in;
      bd_d      = bd_in;
    end else if (eff_exc != '0) begin
      // Faulting instruction: drop its data, keep PC/BD for EPC and Cause.BD.
      valid_d   = 1'b1;
      payload_d = '0;
      pc_d      = pc_in;
      bd_d      = bd_in;
      exc_d     = eff_exc;
    end else begin
      valid_d   = 1'b1;
      payload_d = payload_in;
      pc_d      = pc_in;
      bd_d      = bd_in;
      exc_d     = '0;
    end
  end

  // Stage registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      pc_q      <= '0;
      bd_q      <= 1'b0;
      exc_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      pc_q      <= pc_d;
      bd_q      <= bd_d;
      exc_q     <= exc_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  assign valid_out   = valid_q;
  assign payload_out = payload_q;
  assign pc_out      = pc_q;
  assign bd_out      = bd_q;
  assign exc_out     = exc_q;
  assign has_exc     = valid_q && (exc_q != '0);

endmodule
